// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: request/completion bus between a command source and ps2_host_tx.
//
// Signals:
//   tx_data   command byte to send (valid with tx_valid)
//   tx_valid  request; byte accepted when tx_valid && tx_ready
//   tx_ready  transmitter idle, can accept a byte
//   tx_done   one-cycle pulse: device acknowledged and bus returned to idle
//   tx_err    one-cycle pulse: timeout or missing acknowledge
//
// Modports: master (command source), slave (transmitter).
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done,
    input  tx_err
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done,
    output tx_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter. Sends one command byte to the keyboard
// over the open-collector clock/data lines by driving output enables only (1 = pull low).
// Sequence: inhibit clock, assert start bit, release clock, then present one bit per
// device falling edge (8 data LSB first, odd parity, released stop), check the ack at the
// 11th edge and wait for both lines to float high.
//
// Ports:
//   master_clk   system clock
//   reset        asynchronous, active-high
//   tx           ps2_host_tx_if.slave (tx_data/tx_valid/tx_ready/tx_done/tx_err)
//   rx_inhibit   high whenever the transmitter is busy (state not idle)
//   ps2_clk_in   raw keyboard clock pad level
//   ps2_data_in  raw keyboard data pad level
//   ps2_clk_oe   1 = pull keyboard clock low
//   ps2_data_oe  1 = pull keyboard data low
//
// Optional build macro PS2_TX_RETRY_EN: on no-ack or timeout, re-run the transfer from the
// inhibit phase with the same byte, up to 2 retries, and report tx_err only after the
// third failure. Without the macro the first failure reports tx_err.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic         master_clk,
  input  logic         reset,
  ps2_host_tx_if.slave tx,
  output logic         rx_inhibit,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  // A one-flop synchroniser is not safe on an asynchronous pad.
  localparam int unsigned SyncN  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  // One counter serves both the inhibit phase and the transfer timeout.
  localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                     : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] InhLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] ToLimit = CntW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StStart,
    StShift,
    StWaitIdle
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        n_q, n_d;
  logic [7:0]        sh_q, sh_d;
  logic              par_q, par_d;
  logic              clk_oe_q, clk_oe_d;
  logic              data_oe_q, data_oe_d;
  logic [SyncN-1:0]  clk_sync_q;
  logic [SyncN-1:0]  data_sync_q;
  logic              clk_prev_q;
  logic              clk_s, data_s, clk_fall;
  logic              done, err, fail;

`ifdef PS2_TX_RETRY_EN
  logic [1:0]        retry_q, retry_d;
`endif

  // ---------------------------------------------------------------------------
  // Input synchronisers and falling-edge detect
  // ---------------------------------------------------------------------------
  // Reset to 1 (idle bus level) so no false falling edge appears after reset.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SyncN-2:0], ps2_clk_in};
      data_sync_q <= {data_sync_q[SyncN-2:0], ps2_data_in};
      clk_prev_q  <= clk_s;
    end
  end

  assign clk_s    = clk_sync_q[SyncN-1];
  assign data_s   = data_sync_q[SyncN-1];
  assign clk_fall = clk_prev_q & ~clk_s;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      n_q       <= '0;
      sh_q      <= '0;
      par_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

`ifdef PS2_TX_RETRY_EN
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      retry_q <= 2'd0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    sh_d      = sh_q;
    par_d     = par_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done      = 1'b0;
    err       = 1'b0;
    fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (tx.tx_valid) begin
          state_d   = StInhibit;
          cnt_d     = '0;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          sh_d      = tx.tx_data;
          par_d     = ~^tx.tx_data;
`ifdef PS2_TX_RETRY_EN
          retry_d   = 2'd0;
`endif
        end
      end

      // Device edges are ignored here: the host owns the clock line.
      StInhibit: begin
        if (cnt_q == InhLast) begin
          data_oe_d = 1'b1;
          cnt_d     = '0;
          state_d   = StStart;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      // Start bit and clock low overlap for one cycle before the clock is released.
      StStart: begin
        clk_oe_d = 1'b0;
        n_d      = '0;
        cnt_d    = '0;
        state_d  = StShift;
      end

      // n_q is the number of device falling edges already seen.
      StShift: begin
        if (cnt_q == ToLimit) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (clk_fall) begin
            n_d = n_q + 4'd1;
            if (n_q < 4'd8) begin
              data_oe_d = ~sh_q[n_q[2:0]];
            end else if (n_q == 4'd8) begin
              data_oe_d = ~par_q;
            end else if (n_q == 4'd9) begin
              data_oe_d = 1'b0;
            end else if (!data_s) begin
              state_d = StWaitIdle;
            end else begin
              fail = 1'b1;
            end
          end
        end
      end

      StWaitIdle: begin
        if (cnt_q == ToLimit) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (clk_s && data_s) begin
            done      = 1'b1;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = StIdle;
          end
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = StIdle;
      end
    endcase

    if (fail) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        // Restart from the inhibit phase with the byte already latched.
        retry_d  = retry_q + 2'd1;
        cnt_d    = '0;
        clk_oe_d = 1'b1;
        state_d  = StInhibit;
      end else begin
        err     = 1'b1;
        state_d = StIdle;
      end
`else
      err     = 1'b1;
      state_d = StIdle;
`endif
    end
  end

  // Done/err are asserted in the last busy cycle so tx_ready rises the cycle after.
  assign tx.tx_ready = (state_q == StIdle);
  assign tx.tx_done  = done;
  assign tx.tx_err   = err;
  assign rx_inhibit  = (state_q != StIdle);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: bench for ps2_host_tx with an open-collector keyboard model that clocks
// the frame, records the bit seen at each rising clock, and optionally acknowledges.
// Expected frames come from the byte value (LSB-first data, odd parity, stop = 1).
module tb_ps2_host_tx;

  localparam int unsigned InhCycles = 10;
  localparam int unsigned ToCycles  = 200;
`ifdef PS2_TX_RETRY_EN
  localparam int Attempts = 3;
`else
  localparam int Attempts = 1;
`endif

  logic master_clk = 1'b0;
  logic reset      = 1'b1;
  logic dev_clk    = 1'b1;
  logic dev_data   = 1'b1;
  logic rx_inhibit, ps2_clk_oe, ps2_data_oe;
  logic ps2_clk_in, ps2_data_in;

  ps2_host_tx_if tx_bus ();

  // Wired-AND pads: either side pulls low.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(InhCycles),
    .TIMEOUT_CYCLES(ToCycles),
    .SYNC_STAGES   (2)
  ) dut (
    .master_clk (master_clk),
    .reset      (reset),
    .tx         (tx_bus),
    .rx_inhibit (rx_inhibit),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 master_clk = ~master_clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Line levels the device should read after edges 1..10 (bit k at index k).
  function automatic logic [11:0] model_frame(input logic [7:0] b);
    int ones;
    logic [11:0] f;
    ones = 0;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: samples on the falling system clock edge
  // ---------------------------------------------------------------------------
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, acc_cnt = 0;
  int inh_phases = 0, inh_bad = 0;
  int acc_cyc = 0, done_cyc = 0, err_cyc = 0, rise_cyc = 0, release_cyc = 0;
  int clk_run = 0, last_clk_run = 0, ovl_run = 0, last_ovl_run = 0;
  bit busy_m = 1'b0;
  bit prev_clk_oe = 1'b0;

  always @(negedge master_clk) begin
    cyc++;
    if (reset) begin
      busy_m = 1'b0;
    end else begin
      if (rx_inhibit !== busy_m) inh_bad++;
      if (tx_bus.tx_done && tx_bus.tx_err) both_cnt++;
      if (tx_bus.tx_done) begin done_cnt++; done_cyc = cyc; busy_m = 1'b0; end
      if (tx_bus.tx_err) begin err_cnt++; err_cyc = cyc; busy_m = 1'b0; end
      if (tx_bus.tx_valid && tx_bus.tx_ready) begin acc_cnt++; acc_cyc = cyc; busy_m = 1'b1; end
    end
    if (ps2_clk_oe && !prev_clk_oe) begin
      inh_phases++;
      rise_cyc = cyc;
      clk_run  = 0;
      ovl_run  = 0;
    end
    if (ps2_clk_oe) clk_run++;
    if (ps2_clk_oe && ps2_data_oe) ovl_run++;
    if (!ps2_clk_oe && prev_clk_oe) begin
      last_clk_run = clk_run;
      last_ovl_run = ovl_run;
      release_cyc  = cyc;
    end
    prev_clk_oe = ps2_clk_oe;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 2 time units after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge master_clk);
    #2;
  endtask

  task automatic start_tx(input logic [7:0] b, output bit ok);
    int base;
    int t;
    base = acc_cnt;
    t = 0;
    tx_bus.tx_data  = b;
    tx_bus.tx_valid = 1'b1;
    while (acc_cnt == base && t < 50) begin tick(); t++; end
    tx_bus.tx_valid = 1'b0;
    ok = (acc_cnt != base);
  endtask

  // Device side of one frame. abort_at > 0 returns right after pulling clock low there.
  task automatic dev_xfer(input int edges, input bit ack, input int half, input int abort_at,
                          output logic [11:0] frame, output bit ok);
    int t;
    frame = '0;
    t = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && t < 2000) begin tick(); t++; end
    ok = (t < 2000);
    if (!ok) return;
    for (int k = 1; k <= edges; k++) begin
      if (k == 11 && ack) dev_data = 1'b0;
      tick();
      dev_clk = 1'b0;
      if (k == abort_at) return;
      repeat (half) tick();
      frame[k] = ~ps2_data_oe;
      dev_clk = 1'b1;
      repeat (half) tick();
    end
    dev_data = 1'b1;
    repeat (half) tick();
  endtask

  task automatic wait_result(input int bd, input int be, input int limit);
    int t;
    t = 0;
    while (done_cnt == bd && err_cnt == be && t < limit) begin tick(); t++; end
    tick();
  endtask

  task automatic run_ok(input logic [7:0] b, input int half, input string tag);
    int bd, be;
    bit ok;
    logic [11:0] fr, exp_fr;
    bd = done_cnt;
    be = err_cnt;
    exp_fr = model_frame(b);
    start_tx(b, ok);
    check({tag, "_accept"}, 32'(ok), 32'd1);
    dev_xfer(11, 1'b1, half, 0, fr, ok);
    check({tag, "_request"}, 32'(ok), 32'd1);
    wait_result(bd, be, 500);
    check({tag, "_frame"}, 32'(fr[10:1]), 32'(exp_fr[10:1]));
    check({tag, "_done_err"}, {done_cnt - bd, err_cnt - be}, {32'd1, 32'd0});
    check({tag, "_ready"}, 32'(tx_bus.tx_ready), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit ok;
    int bd, be, base, inh0, t;
    logic [11:0] fr, fa;
    logic [7:0] a_byte, b_byte;

    tx_bus.tx_valid = 1'b0;
    tx_bus.tx_data  = 8'h00;
    repeat (3) tick();
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("rst_flags", {tx_bus.tx_ready, tx_bus.tx_done, tx_bus.tx_err, rx_inhibit}, 4'b1000);
    reset = 1'b0;
    repeat (2) tick();

    // Set-LEDs command, then a single-one byte with inhibit timing checks.
    run_ok(8'hED, 6, "ed");
    run_ok(8'h01, 5, "x01");
    check("clk_oe_len", last_clk_run, InhCycles + 1);
    check("clk_data_overlap", last_ovl_run, 1);
    check("accept_to_clk_oe", rise_cyc - acc_cyc, 1);

    // No acknowledge at the 11th edge.
    bd = done_cnt; be = err_cnt; inh0 = inh_phases;
    start_tx(8'hFF, ok);
    check("noack_accept", 32'(ok), 32'd1);
    for (int a = 0; a < Attempts; a++) begin
      dev_xfer(11, 1'b0, 5, 0, fr, ok);
      check("noack_request", 32'(ok), 32'd1);
    end
    wait_result(bd, be, 500);
    check("noack_done_err", {done_cnt - bd, err_cnt - be}, {32'd0, 32'd1});
    check("noack_inhibits", inh_phases - inh0, Attempts);

    // Device stops after 5 edges: timeout measured from the last clock release.
    bd = done_cnt; be = err_cnt;
    start_tx(8'hF4, ok);
    check("to_accept", 32'(ok), 32'd1);
    for (int a = 0; a < Attempts; a++) begin
      dev_xfer(5, 1'b1, 5, 0, fr, ok);
      check("to_request", 32'(ok), 32'd1);
      t = 0;
      while (done_cnt == bd && err_cnt == be && !ps2_clk_oe && t < 1000) begin tick(); t++; end
    end
    wait_result(bd, be, 1000);
    check("to_done_err", {done_cnt - bd, err_cnt - be}, {32'd0, 32'd1});
    check("to_latency", err_cyc - release_cyc, ToCycles);
    check("to_oe_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    // Reset in the middle of a transfer releases the lines at once.
    bd = done_cnt; be = err_cnt;
    start_tx(8'h00, ok);
    check("rst_mid_accept", 32'(ok), 32'd1);
    dev_xfer(11, 1'b1, 5, 6, fr, ok);
    check("rst_mid_request", 32'(ok), 32'd1);
    repeat (4) tick();
    check("rst_mid_busy", 32'(rx_inhibit), 32'd1);
    @(posedge master_clk);
    #3;
    reset = 1'b1;
    #1;
    check("rst_mid_oe", {ps2_clk_oe, ps2_data_oe, tx_bus.tx_ready}, 3'b001);
    repeat (2) tick();
    reset    = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) tick();
    check("rst_mid_no_pulse", {done_cnt - bd, err_cnt - be}, {32'd0, 32'd0});
    run_ok(8'($urandom), 5, "after_rst");

    // tx_valid held across two transfers with different bytes.
    a_byte = 8'($urandom);
    b_byte = a_byte ^ 8'h5A;
    bd = done_cnt; be = err_cnt; base = acc_cnt;
    tx_bus.tx_data  = a_byte;
    tx_bus.tx_valid = 1'b1;
    t = 0;
    while (acc_cnt == base && t < 50) begin tick(); t++; end
    tx_bus.tx_data = b_byte;
    dev_xfer(11, 1'b1, 5, 0, fa, ok);
    check("hold_req_a", 32'(ok), 32'd1);
    t = 0;
    while (acc_cnt < base + 2 && t < 500) begin tick(); t++; end
    tx_bus.tx_valid = 1'b0;
    check("hold_accepts", acc_cnt - base, 2);
    check("hold_accept_after_done", acc_cyc - done_cyc, 1);
    dev_xfer(11, 1'b1, 5, 0, fr, ok);
    check("hold_req_b", 32'(ok), 32'd1);
    wait_result(bd + 1, be, 500);
    check("hold_frame_a", 32'(fa[10:1]), 32'(model_frame(a_byte) >> 1) & 32'h3FF);
    check("hold_frame_b", 32'(fr[10:1]), 32'(model_frame(b_byte) >> 1) & 32'h3FF);
    check("hold_done_err", {done_cnt - bd, err_cnt - be}, {32'd2, 32'd0});

    // Random bytes at random device clock rates.
    for (int i = 0; i < 6; i++) begin
      run_ok(8'($urandom), int'($urandom_range(4, 6)), "rand");
    end

    check("never_done_and_err", both_cnt, 0);
    check("rx_inhibit_tracks_busy", inh_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
